multicycle_control_unit: RTL
============================

# multicycle_control_unit

Parametrised multicycle sequencer for the RISC-V processor, replacing the fixed fetch/decode control unit. It walks each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK states, and holds in FETCH or MEMORY until memory acknowledges. It drives the datapath strobes, halts cleanly on ECALL/EBREAK, illegal opcodes or memory timeout, and supports single-step debug. It also keeps cycle and retired-instruction counters.

## Interface
Parameters:
- WORDSIZE, 64: width of the cycle and instret counters.
- INSTRUCTION_SIZE, 32: instruction width; only bits [6:0] (opcode) are consumed.
- MEM_TIMEOUT, 15: maximum cycles spent waiting on mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- opcode  in  7  opcode of the current instruction; sampled in DECODE.
- mem_ready  in  1  instruction/data memory acknowledge.
- step_mode  in  1  1 = pause after every retired instruction.
- step  in  1  releases the pause; level-sampled in PAUSE.
- fetch, decode, execute, mem_access, writeback  out  1 each  one-hot state strobes.
- rf_write_en  out  1  register-file write strobe.
- dm_write_en  out  1  data-memory write strobe.
- pc_write_en  out  1  PC update strobe.
- finished  out  1  high while in HALT.
- halt_cause  out  2  00 none, 01 ECALL/EBREAK, 10 illegal opcode, 11 memory timeout.
- cycle_count  out  WORDSIZE  count of non-HALT cycles since reset.
- instret  out  WORDSIZE  count of retired instructions.

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PAUSE, HALT.
- Outputs are Moore-decoded from the registered state.
- FETCH: fetch=1.
  - mem_ready=1 -> DECODE.
  - Otherwise stay in FETCH, with wait counting.
- DECODE: decode=1. Opcode classification:
  - LOAD 0000011, STORE 0100011 -> EXECUTE, memory class.
  - OP-IMM 0010011, OP 0110011, OP-IMM-32 0011011, OP-32 0111011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011 -> EXECUTE, non-memory class.
  - SYSTEM 1110011 -> HALT, cause 01.
  - Any other opcode -> HALT, cause 10.
- EXECUTE: execute=1. Memory class -> MEMORY; otherwise -> WRITEBACK.
- MEMORY: mem_access=1.
  - dm_write_en=1 for STORE during every MEMORY cycle.
  - mem_ready=1 -> WRITEBACK; otherwise stay, with wait counting.
- WRITEBACK: writeback=1, pc_write_en=1.
  - rf_write_en=1 unless opcode is STORE or BRANCH.
  - instret increments.
  - Next state: PAUSE if step_mode=1, else FETCH.
- PAUSE: all strobes 0. step=1 or step_mode=0 -> FETCH.
- HALT: finished=1, all strobes 0, counters frozen, halt_cause held. Only rst_n leaves HALT.
- Decoded class and opcode are registered in DECODE and held until the next DECODE; later opcode changes are ignored.
- Wait counter:
  - Clears on entry to FETCH or MEMORY.
  - Increments each cycle spent there with mem_ready=0.
  - If MEM_TIMEOUT≠0 and the count equals MEM_TIMEOUT while mem_ready=0 -> HALT, cause 11.
  - mem_ready=1 in the same cycle wins over timeout.
- Counters wrap modulo 2^WORDSIZE. cycle_count increments in every state except HALT.

## Timing
- Reset: rst_n=0 at a rising edge loads state FETCH and clears counters, halt_cause and wait counter.
  - Output values after that edge: fetch=1, every other output 0.
  - Reset mid-instruction or in HALT aborts immediately; no write strobe is issued.
- Latency with mem_ready tied to 1:
  - ALU, branch and jump instructions: 4 cycles (F, D, E, W).
  - Load and store: 5 cycles (F, D, E, M, W).
  - SYSTEM: 2 cycles, then finished rises.
- Each wait cycle adds 1 to the relevant latency.
- rf_write_en and pc_write_en are exactly one-cycle pulses per instruction.
- step is level-sensitive: holding it high steps continuously, one instruction per pass through PAUSE. PAUSE lasts at least 1 cycle.

## Test plan
- ADD (0110011), mem_ready=1 -> states F, D, E, W.
  - rf_write_en and pc_write_en high only in W.
  - instret=1 after W; cycle_count=4 at the next FETCH.
- STORE (0100011) with mem_ready low for 3 MEMORY cycles -> dm_write_en high for 4 cycles, rf_write_en never asserted, total latency 8.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> HALT after 4 wait cycles.
  - halt_cause=11, finished=1, cycle_count frozen.
- Opcode 1111111 -> HALT after DECODE, halt_cause=10. Opcode 1110011 -> halt_cause=01. No rf_write_en in either case.
- step_mode=1, three ADDs -> PAUSE after each W. Each step pulse advances exactly one instruction; instret goes 1, 2, 3.
- rst_n low in the MEMORY cycle of a STORE -> next cycle fetch=1, dm_write_en=0, both counters 0.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: sequencer inputs, datapath strobes,
// halt status and counters bundled for the control unit.
interface multicycle_control_unit_if #(
  parameter int WORDSIZE = 64
);
  logic [6:0]          opcode;
  logic                mem_ready;
  logic                step_mode;
  logic                step;
  logic                fetch;
  logic                decode;
  logic                execute;
  logic                mem_access;
  logic                writeback;
  logic                rf_write_en;
  logic                dm_write_en;
  logic                pc_write_en;
  logic                finished;
  logic [1:0]          halt_cause;
  logic [WORDSIZE-1:0] cycle_count;
  logic [WORDSIZE-1:0] instret;

  modport master (
    output opcode, mem_ready, step_mode, step,
    input  fetch, decode, execute, mem_access, writeback,
    input  rf_write_en, dm_write_en, pc_write_en,
    input  finished, halt_cause, cycle_count, instret
  );

  modport slave (
    input  opcode, mem_ready, step_mode, step,
    output fetch, decode, execute, mem_access, writeback,
    output rf_write_en, dm_write_en, pc_write_en,
    output finished, halt_cause, cycle_count, instret
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: F/D/E/M/W sequencer with step pause, halt,
// memory-wait timeout and cycle/instret counters.
module multicycle_control_unit #(
  parameter int WORDSIZE         = 64,
  parameter int INSTRUCTION_SIZE = 32,
  parameter int MEM_TIMEOUT      = 15
) (
  input logic clk,
  input logic rst_n,
  multicycle_control_unit_if.slave bus
);
  localparam int OPC_W =
    (INSTRUCTION_SIZE < 7) ? INSTRUCTION_SIZE : 7;
  localparam int WW =
    (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TO_VAL = WW'(MEM_TIMEOUT);
  localparam bit TO_EN = (MEM_TIMEOUT != 0);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_PAUSE,
    S_HALT
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_cause;
  logic [1:0]          w_cause;
  logic [WW-1:0]       r_wait;
  logic [WW-1:0]       w_wait_inc;
  logic                w_waiting;
  logic                w_timeout;
  logic [WORDSIZE-1:0] r_cycle;
  logic [WORDSIZE-1:0] r_instret;
  logic [OPC_W-1:0]    r_opc;
  logic                r_is_mem;
  logic                w_is_mem;
  logic                w_is_alu;
  logic                w_is_sys;
  logic                w_r_store;
  logic                w_r_norf;
  logic                r_fetch;
  logic                r_decode;
  logic                r_exec;
  logic                r_mem;
  logic                r_wb;
  logic                r_rf_we;
  logic                r_dm_we;
  logic                r_pc_we;
  logic                r_fin;

  assign w_wait_inc = r_wait + 1'b1;
  assign w_waiting  = ((r_state == S_FETCH) ||
                       (r_state == S_MEM)) &&
                      !bus.mem_ready;
  assign w_timeout  = TO_EN && (w_wait_inc == TO_VAL);

  assign w_r_store = (r_opc == OPC_W'(OP_STORE));
  assign w_r_norf  = w_r_store ||
                     (r_opc == OPC_W'(OP_BRANCH));

  // classify the live opcode; only consumed while in DECODE
  always_comb begin
    w_is_mem = (bus.opcode == OP_LOAD) ||
               (bus.opcode == OP_STORE);
    w_is_alu = (bus.opcode == OP_IMM)   ||
               (bus.opcode == OP_OP)    ||
               (bus.opcode == OP_IMM32) ||
               (bus.opcode == OP_OP32)  ||
               (bus.opcode == OP_LUI)   ||
               (bus.opcode == OP_AUIPC) ||
               (bus.opcode == OP_JAL)   ||
               (bus.opcode == OP_JALR)  ||
               (bus.opcode == OP_BRANCH);
    w_is_sys = (bus.opcode == OP_SYSTEM);
  end

  // next state and halt cause; mem_ready beats timeout
  always_comb begin
    w_next  = r_state;
    w_cause = r_cause;
    unique case (r_state)
      S_FETCH: begin
        if (bus.mem_ready) begin
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next  = S_HALT;
          w_cause = 2'b11;
        end
      end
      S_DECODE: begin
        if (w_is_mem || w_is_alu) begin
          w_next = S_EXEC;
        end else if (w_is_sys) begin
          w_next  = S_HALT;
          w_cause = 2'b01;
        end else begin
          w_next  = S_HALT;
          w_cause = 2'b10;
        end
      end
      S_EXEC: w_next = r_is_mem ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.mem_ready) begin
          w_next = S_WB;
        end else if (w_timeout) begin
          w_next  = S_HALT;
          w_cause = 2'b11;
        end
      end
      S_WB: begin
        w_next = bus.step_mode ? S_PAUSE : S_FETCH;
      end
      S_PAUSE: begin
        if (bus.step || !bus.step_mode) begin
          w_next = S_FETCH;
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
  end

  // state, counters, latched decode and registered strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_cause   <= 2'b00;
      r_wait    <= '0;
      r_cycle   <= '0;
      r_instret <= '0;
      r_opc     <= '0;
      r_is_mem  <= 1'b0;
      r_fetch   <= 1'b1;
      r_decode  <= 1'b0;
      r_exec    <= 1'b0;
      r_mem     <= 1'b0;
      r_wb      <= 1'b0;
      r_rf_we   <= 1'b0;
      r_dm_we   <= 1'b0;
      r_pc_we   <= 1'b0;
      r_fin     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause;
      if (r_state != S_HALT) begin
        r_cycle <= r_cycle + 1'b1;
      end
      if (r_state == S_WB) begin
        r_instret <= r_instret + 1'b1;
      end
      if (w_waiting) begin
        r_wait <= w_wait_inc;
      end else begin
        r_wait <= '0;
      end
      if (r_state == S_DECODE) begin
        r_opc    <= bus.opcode[OPC_W-1:0];
        r_is_mem <= w_is_mem;
      end
      r_fetch  <= (w_next == S_FETCH);
      r_decode <= (w_next == S_DECODE);
      r_exec   <= (w_next == S_EXEC);
      r_mem    <= (w_next == S_MEM);
      r_wb     <= (w_next == S_WB);
      r_rf_we  <= (w_next == S_WB) && !w_r_norf;
      r_dm_we  <= (w_next == S_MEM) && w_r_store;
      r_pc_we  <= (w_next == S_WB);
      r_fin    <= (w_next == S_HALT);
    end
  end

  assign bus.fetch       = r_fetch;
  assign bus.decode      = r_decode;
  assign bus.execute     = r_exec;
  assign bus.mem_access  = r_mem;
  assign bus.writeback   = r_wb;
  assign bus.rf_write_en = r_rf_we;
  assign bus.dm_write_en = r_dm_we;
  assign bus.pc_write_en = r_pc_we;
  assign bus.finished    = r_fin;
  assign bus.halt_cause  = r_cause;
  assign bus.cycle_count = r_cycle;
  assign bus.instret     = r_instret;
endmodule
